// File: rtl/flag_branch_unit.sv
// Flags latch, conditional-branch evaluator and program counter owner.
// Optional BRANCH_STATS_EN adds saturating taken/not-taken counters.
module flag_branch_unit #(
  parameter int                   WORD_SIZE    = 8,
  parameter logic [WORD_SIZE-1:0] RESET_VECTOR = '0,
  parameter int                   FLUSH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           alu_flags,
  input  logic                 flags_we,
  input  logic                 br_valid,
  output logic                 br_ready,
  input  logic [3:0]           br_cond,
  input  logic [WORD_SIZE-1:0] br_target,
  input  logic                 pc_advance,
  output logic [WORD_SIZE-1:0] pc,
  output logic                 flush,
  output logic                 taken,
  output logic [3:0]           flags_q
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]          taken_count,
  output logic [15:0]          not_taken_count
`endif
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t               state_q;
  logic [WORD_SIZE-1:0] pc_q;
  logic [WORD_SIZE-1:0] target_q;
  logic [3:0]           cond_q;
  logic [3:0]           flagsReg_q;
  logic [CW-1:0]        flushCnt_q;
  logic                 flush_q;
  logic                 taken_q;
  logic                 ready_q;
  logic                 condMet;
  logic                 unusedLowFlags;

  assign unusedLowFlags = ^alu_flags[3:0];

  // Flag nibble order is {Z,S,C,O}; signed compares use S^O as "less than".
  function automatic logic evalCond(input logic [3:0] cond, input logic [3:0] f);
    logic z, s, c, o;
    z = f[3];
    s = f[2];
    c = f[1];
    o = f[0];
    case (cond)
      4'd0:    evalCond = 1'b1;
      4'd1:    evalCond = z;
      4'd2:    evalCond = !z;
      4'd3:    evalCond = s;
      4'd4:    evalCond = !s;
      4'd5:    evalCond = c;
      4'd6:    evalCond = !c;
      4'd7:    evalCond = o;
      4'd8:    evalCond = !o;
      4'd9:    evalCond = !c && !z;
      4'd10:   evalCond = c || z;
      4'd11:   evalCond = s ^ o;
      4'd12:   evalCond = !(s ^ o);
      4'd13:   evalCond = !z && !(s ^ o);
      4'd14:   evalCond = z || (s ^ o);
      default: evalCond = 1'b0;
    endcase
  endfunction

  assign condMet = evalCond(cond_q, flagsReg_q);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_VECTOR;
      target_q   <= '0;
      cond_q     <= '0;
      flagsReg_q <= '0;
      flushCnt_q <= '0;
      flush_q    <= 1'b0;
      taken_q    <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      if (flags_we) begin
        flagsReg_q <= alu_flags[7:4];
      end
      case (state_q)
        IDLE: begin
          if (pc_advance) begin
            pc_q <= pc_q + WORD_SIZE'(1);
          end
          if (br_valid) begin
            cond_q   <= br_cond;
            target_q <= br_target;
            ready_q  <= 1'b0;
            state_q  <= EVAL;
          end
        end
        EVAL: begin
          // Decision uses the flags register as it stands now, not this edge's write.
          if (condMet) begin
            pc_q       <= target_q;
            taken_q    <= 1'b1;
            flush_q    <= 1'b1;
            flushCnt_q <= CW'(FLUSH_CYCLES);
            state_q    <= FLUSH;
          end else begin
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        FLUSH: begin
          taken_q <= 1'b0;
          if (flushCnt_q <= CW'(1)) begin
            flushCnt_q <= '0;
            flush_q    <= 1'b0;
            ready_q    <= 1'b1;
            state_q    <= IDLE;
          end else begin
            flushCnt_q <= flushCnt_q - CW'(1);
          end
        end
        default: begin
          flush_q <= 1'b0;
          taken_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic [15:0] takenCnt_q;
  logic [15:0] notTakenCnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      takenCnt_q    <= '0;
      notTakenCnt_q <= '0;
    end else if (state_q == EVAL) begin
      if (condMet) begin
        if (takenCnt_q != 16'hFFFF) takenCnt_q <= takenCnt_q + 16'd1;
      end else begin
        if (notTakenCnt_q != 16'hFFFF) notTakenCnt_q <= notTakenCnt_q + 16'd1;
      end
    end
  end

  assign taken_count     = takenCnt_q;
  assign not_taken_count = notTakenCnt_q;
`endif

  assign pc       = pc_q;
  assign flush    = flush_q;
  assign taken    = taken_q;
  assign br_ready = ready_q;
  assign flags_q  = flagsReg_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Scoreboard bench for flag_branch_unit: stimulus pushes hand-computed
// expected outputs, a monitor pops and compares one entry after each edge.
module tb_flag_branch_unit;

  logic       clk;
  logic       reset_n;
  logic [7:0] alu_flags;
  logic       flags_we;
  logic       br_valid;
  logic       br_ready;
  logic [3:0] br_cond;
  logic [7:0] br_target;
  logic       pc_advance;
  logic [7:0] pc;
  logic       flush;
  logic       taken;
  logic [3:0] flags_q;
`ifdef BRANCH_STATS_EN
  logic [15:0] taken_count;
  logic [15:0] not_taken_count;
`endif

  typedef struct packed {
    logic [7:0] pc;
    logic       flush;
    logic       taken;
    logic       ready;
    logic [3:0] flags;
  } outs_t;

  typedef struct {
    string name;
    outs_t exp;
  } item_t;

  item_t expQ[$];
  int    checkCount = 0;
  int    passCount  = 0;

  flag_branch_unit #(
    .WORD_SIZE   (8),
    .RESET_VECTOR(8'h10),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .alu_flags (alu_flags),
    .flags_we  (flags_we),
    .br_valid  (br_valid),
    .br_ready  (br_ready),
    .br_cond   (br_cond),
    .br_target (br_target),
    .pc_advance(pc_advance),
    .pc        (pc),
    .flush     (flush),
    .taken     (taken),
    .flags_q   (flags_q)
`ifdef BRANCH_STATS_EN
    ,
    .taken_count    (taken_count),
    .not_taken_count(not_taken_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One call = one clock edge; the expectation describes outputs after that edge.
  task automatic applyStimulus(input string name, input logic rstN, input logic we,
                               input logic [7:0] alu, input logic valid,
                               input logic [3:0] cond, input logic [7:0] target,
                               input logic adv, input logic [7:0] ePc,
                               input logic eFlush, input logic eTaken,
                               input logic eReady, input logic [3:0] eFlags);
    item_t it;
    @(negedge clk);
    reset_n    = rstN;
    flags_we   = we;
    alu_flags  = alu;
    br_valid   = valid;
    br_cond    = cond;
    br_target  = target;
    pc_advance = adv;
    it.name = name;
    it.exp  = '{pc: ePc, flush: eFlush, taken: eTaken, ready: eReady, flags: eFlags};
    expQ.push_back(it);
  endtask

  task automatic checkOutput(input item_t it);
    outs_t act;
    act = '{pc: pc, flush: flush, taken: taken, ready: br_ready, flags: flags_q};
    checkCount++;
    if (act === it.exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got pc=%h flush=%b taken=%b ready=%b flags=%h, expected pc=%h flush=%b taken=%b ready=%b flags=%h",
               it.name, act.pc, act.flush, act.taken, act.ready, act.flags,
               it.exp.pc, it.exp.flush, it.exp.taken, it.exp.ready, it.exp.flags);
    end
  endtask

  task automatic checkValue(input string name, input logic [15:0] act, input logic [15:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: sample just after every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin
    reset_n    = 1'b0;
    flags_we   = 1'b0;
    alu_flags  = 8'h00;
    br_valid   = 1'b0;
    br_cond    = 4'd0;
    br_target  = 8'h00;
    pc_advance = 1'b0;

    //            name          rst we alu    vld cond   tgt    adv  pc     fl    tk    rdy   flags
    applyStimulus("reset",      0, 0, 8'h00, 0, 4'd0,  8'h00, 0, 8'h10, 1'b0, 1'b0, 1'b1, 4'h0);
    applyStimulus("idle",       1, 0, 8'h00, 0, 4'd0,  8'h00, 0, 8'h10, 1'b0, 1'b0, 1'b1, 4'h0);
    applyStimulus("accALW",     1, 0, 8'h00, 1, 4'd0,  8'hFE, 1, 8'h11, 1'b0, 1'b0, 1'b0, 4'h0);
    applyStimulus("evalALW",    1, 0, 8'h00, 0, 4'd0,  8'h00, 1, 8'hFE, 1'b1, 1'b1, 1'b0, 4'h0);
    applyStimulus("flushALW1",  1, 0, 8'h00, 0, 4'd0,  8'h00, 1, 8'hFE, 1'b1, 1'b0, 1'b0, 4'h0);
    applyStimulus("flushALW2",  1, 0, 8'h00, 0, 4'd0,  8'h00, 0, 8'hFE, 1'b0, 1'b0, 1'b1, 4'h0);
    applyStimulus("advFF",      1, 0, 8'h00, 0, 4'd0,  8'h00, 1, 8'hFF, 1'b0, 1'b0, 1'b1, 4'h0);
    applyStimulus("adv00",      1, 0, 8'h00, 0, 4'd0,  8'h00, 1, 8'h00, 1'b0, 1'b0, 1'b1, 4'h0);
    applyStimulus("adv01",      1, 0, 8'h00, 0, 4'd0,  8'h00, 1, 8'h01, 1'b0, 1'b0, 1'b1, 4'h0);
    applyStimulus("flagsZ",     1, 1, 8'h80, 0, 4'd0,  8'h00, 0, 8'h01, 1'b0, 1'b0, 1'b1, 4'h8);
    applyStimulus("accJZ",      1, 0, 8'h00, 1, 4'd1,  8'h40, 0, 8'h01, 1'b0, 1'b0, 1'b0, 4'h8);
    applyStimulus("evalJZ",     1, 0, 8'h00, 0, 4'd0,  8'h00, 0, 8'h40, 1'b1, 1'b1, 1'b0, 4'h8);
    applyStimulus("flushJZ1",   1, 0, 8'h00, 0, 4'd0,  8'h00, 0, 8'h40, 1'b1, 1'b0, 1'b0, 4'h8);
    applyStimulus("flushJZ2",   1, 0, 8'h00, 0, 4'd0,  8'h00, 0, 8'h40, 1'b0, 1'b0, 1'b1, 4'h8);
    applyStimulus("flagsSO",    1, 1, 8'h50, 0, 4'd0,  8'h00, 0, 8'h40, 1'b0, 1'b0, 1'b1, 4'h5);
    applyStimulus("accJL",      1, 0, 8'h00, 1, 4'd11, 8'h77, 0, 8'h40, 1'b0, 1'b0, 1'b0, 4'h5);
    applyStimulus("evalJL",     1, 0, 8'h00, 0, 4'd0,  8'h00, 0, 8'h40, 1'b0, 1'b0, 1'b1, 4'h5);
    applyStimulus("idleJL",     1, 0, 8'h00, 0, 4'd0,  8'h00, 0, 8'h40, 1'b0, 1'b0, 1'b1, 4'h5);
    applyStimulus("accJC",      1, 1, 8'h20, 1, 4'd5,  8'h33, 0, 8'h40, 1'b0, 1'b0, 1'b0, 4'h2);
    applyStimulus("evalJC",     1, 1, 8'h00, 1, 4'd5,  8'h33, 0, 8'h33, 1'b1, 1'b1, 1'b0, 4'h0);
    applyStimulus("flushJC1",   1, 0, 8'h00, 1, 4'd5,  8'h33, 1, 8'h33, 1'b1, 1'b0, 1'b0, 4'h0);
`ifdef BRANCH_STATS_EN
    checkValue("takenCountBeforeReset", taken_count, 16'd3);
    checkValue("notTakenCountBeforeReset", not_taken_count, 16'd1);
`endif
    applyStimulus("rstInFlush", 0, 0, 8'h00, 1, 4'd5,  8'h33, 1, 8'h10, 1'b0, 1'b0, 1'b1, 4'h0);
    applyStimulus("postReset",  1, 0, 8'h00, 0, 4'd0,  8'h00, 0, 8'h10, 1'b0, 1'b0, 1'b1, 4'h0);
`ifdef BRANCH_STATS_EN
    checkValue("takenCountAfterReset", taken_count, 16'd0);
    checkValue("notTakenCountAfterReset", not_taken_count, 16'd0);
`endif
    applyStimulus("accNEVER",   1, 0, 8'h00, 1, 4'd15, 8'h99, 0, 8'h10, 1'b0, 1'b0, 1'b0, 4'h0);
    applyStimulus("evalNEVER",  1, 0, 8'h00, 0, 4'd0,  8'h00, 0, 8'h10, 1'b0, 1'b0, 1'b1, 4'h0);
    applyStimulus("accJNZ",     1, 0, 8'h00, 1, 4'd2,  8'h5A, 1, 8'h11, 1'b0, 1'b0, 1'b0, 4'h0);
    applyStimulus("evalJNZ",    1, 0, 8'h00, 0, 4'd0,  8'h00, 0, 8'h5A, 1'b1, 1'b1, 1'b0, 4'h0);
    applyStimulus("flushJNZ1",  1, 0, 8'h00, 0, 4'd0,  8'h00, 0, 8'h5A, 1'b1, 1'b0, 1'b0, 4'h0);
    applyStimulus("flushJNZ2",  1, 0, 8'h00, 0, 4'd0,  8'h00, 0, 8'h5A, 1'b0, 1'b0, 1'b1, 4'h0);

    @(negedge clk);
    @(negedge clk);
    checkValue("scoreboardDrained", 16'(expQ.size()), 16'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
